ysyx_22040237_idu_stage: RTL and testbench

Pipelined, parametrised decode stage for the RV core. It sits between IFU and EXU:
- accepts an instruction and PC from IFU over a valid/ready handshake;
- drives register-file read ports combinationally;
- captures the decoded opcode, operands and writeback control into an output register;
- presents that register to EXU over a valid/ready handshake.

It generalises the single-cycle decoder with XLEN width, more instructions, illegal-instruction detection, back-pressure and flush.

---
 rtl/ysyx_22040237_idu_stage_if.sv | 55 +++++
 rtl/ysyx_22040237_idu_stage.sv | 180 ++++++++++++++++++
 tb/tb_ysyx_22040237_idu_stage.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040237_idu_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22040237_idu_stage_if
//  Description : Bundle of IFU-side handshake, register-file read ports and
//                EXU-side handshake for the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_22040237_idu_stage_if #(
    parameter int XLEN  = 64,
    parameter int OPC_W = 8,
    parameter int RF_AW = 5
);
    // IFU side
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_inst;
    logic [XLEN-1:0]    in_pc;
    logic               flush;

    // Register-file read ports
    logic               rs1_r_en;
    logic [RF_AW-1:0]   rs1_r_addr;
    logic [XLEN-1:0]    rs1_data;
    logic               rs2_r_en;
    logic [RF_AW-1:0]   rs2_r_addr;
    logic [XLEN-1:0]    rs2_data;

    // EXU side
    logic               out_valid;
    logic               out_ready;
    logic [OPC_W-1:0]   out_opcode;
    logic [XLEN-1:0]    out_op1;
    logic [XLEN-1:0]    out_op2;
    logic [XLEN-1:0]    out_pc;
    logic               out_rd_w_en;
    logic [RF_AW-1:0]   out_rd_w_addr;
    logic               out_illegal;

    // Decode-stage view
    modport slave (
        input  in_valid, in_inst, in_pc, flush, rs1_data, rs2_data, out_ready,
        output in_ready, rs1_r_en, rs1_r_addr, rs2_r_en, rs2_r_addr,
               out_valid, out_opcode, out_op1, out_op2, out_pc,
               out_rd_w_en, out_rd_w_addr, out_illegal
    );

    // Surrounding pipeline / register-file view
    modport master (
        output in_valid, in_inst, in_pc, flush, rs1_data, rs2_data, out_ready,
        input  in_ready, rs1_r_en, rs1_r_addr, rs2_r_en, rs2_r_addr,
               out_valid, out_opcode, out_op1, out_op2, out_pc,
               out_rd_w_en, out_rd_w_addr, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22040237_idu_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22040237_idu_stage
//  Description : Pipelined decode stage. Decodes the IFU instruction, reads
//                the register file combinationally and registers the decoded
//                bundle towards EXU behind a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040237_idu_stage #(
    parameter int XLEN  = 64,
    parameter int OPC_W = 8,
    parameter int RF_AW = 5
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    ysyx_22040237_idu_stage_if.slave    bus
);

    // RISC-V major opcodes
    localparam logic [6:0]  c_opc_op_imm = 7'b0010011;
    localparam logic [6:0]  c_opc_op     = 7'b0110011;
    localparam logic [6:0]  c_opc_lui    = 7'b0110111;
    localparam logic [6:0]  c_opc_auipc  = 7'b0010111;
    localparam logic [31:0] c_ebreak     = 32'h0010_0073;

    // Internal opcode codes handed to EXU
    localparam logic [OPC_W-1:0] c_code_add   = OPC_W'(8'h01);
    localparam logic [OPC_W-1:0] c_code_sub   = OPC_W'(8'h02);
    localparam logic [OPC_W-1:0] c_code_addi  = OPC_W'(8'h11);
    localparam logic [OPC_W-1:0] c_code_lui   = OPC_W'(8'h21);
    localparam logic [OPC_W-1:0] c_code_auipc = OPC_W'(8'h22);
    localparam logic [OPC_W-1:0] c_code_ebrk  = OPC_W'(8'hF0);

    // Field extraction
    logic [6:0]         w_opc;
    logic [2:0]         w_f3;
    logic [6:0]         w_f7;
    logic [RF_AW-1:0]   w_rd;
    logic [XLEN-1:0]    w_imm_i;
    logic [XLEN-1:0]    w_imm_u;

    assign w_opc   = bus.in_inst[6:0];
    assign w_f3    = bus.in_inst[14:12];
    assign w_f7    = bus.in_inst[31:25];
    assign w_rd    = RF_AW'(bus.in_inst[11:7]);
    // Size casts of signed values sign-extend to XLEN
    assign w_imm_i = XLEN'($signed(bus.in_inst[31:20]));
    assign w_imm_u = XLEN'($signed({bus.in_inst[31:12], 12'b0}));

    // Instruction classification
    logic w_is_addi;
    logic w_is_add;
    logic w_is_sub;
    logic w_is_lui;
    logic w_is_auipc;
    logic w_is_ebreak;

    assign w_is_addi   = (w_opc == c_opc_op_imm) && (w_f3 == 3'b000);
    assign w_is_add    = (w_opc == c_opc_op) && (w_f3 == 3'b000) && (w_f7 == 7'b0000000);
    assign w_is_sub    = (w_opc == c_opc_op) && (w_f3 == 3'b000) && (w_f7 == 7'b0100000);
    assign w_is_lui    = (w_opc == c_opc_lui);
    assign w_is_auipc  = (w_opc == c_opc_auipc);
    assign w_is_ebreak = (bus.in_inst == c_ebreak);

    // Handshake
    logic r_out_valid;
    logic w_in_ready;
    logic w_rd_fire;
    logic w_accept;

    assign w_in_ready = ~r_out_valid | bus.out_ready;
    // Read ports are only driven for a real transfer; quiet during reset/stall
    assign w_rd_fire  = bus.in_valid & w_in_ready & ~rst;
    assign w_accept   = bus.in_valid & w_in_ready & ~bus.flush;

    // Register-file read ports
    logic w_rs1_en;
    logic w_rs2_en;

    assign w_rs1_en       = w_rd_fire & (w_is_addi | w_is_add | w_is_sub);
    assign w_rs2_en       = w_rd_fire & (w_is_add | w_is_sub);
    assign bus.rs1_r_en   = w_rs1_en;
    assign bus.rs2_r_en   = w_rs2_en;
    assign bus.rs1_r_addr = w_rs1_en ? RF_AW'(bus.in_inst[19:15]) : '0;
    assign bus.rs2_r_addr = w_rs2_en ? RF_AW'(bus.in_inst[24:20]) : '0;
    assign bus.in_ready   = w_in_ready;

    // Next-bundle decode; anything unrecognised falls through as illegal
    logic [OPC_W-1:0]   w_code;
    logic [XLEN-1:0]    w_op1;
    logic [XLEN-1:0]    w_op2;
    logic               w_we;
    logic               w_illegal;

    // Decode table
    always_comb begin
        w_code    = '0;
        w_op1     = '0;
        w_op2     = '0;
        w_we      = 1'b0;
        w_illegal = 1'b0;
        if (w_is_ebreak) begin
            w_code = c_code_ebrk;
        end else if (w_is_addi) begin
            w_code = c_code_addi;
            w_op1  = bus.rs1_data;
            w_op2  = w_imm_i;
            w_we   = 1'b1;
        end else if (w_is_add) begin
            w_code = c_code_add;
            w_op1  = bus.rs1_data;
            w_op2  = bus.rs2_data;
            w_we   = 1'b1;
        end else if (w_is_sub) begin
            w_code = c_code_sub;
            w_op1  = bus.rs1_data;
            w_op2  = bus.rs2_data;
            w_we   = 1'b1;
        end else if (w_is_lui) begin
            w_code = c_code_lui;
            w_op2  = w_imm_u;
            w_we   = 1'b1;
        end else if (w_is_auipc) begin
            w_code = c_code_auipc;
            w_op1  = bus.in_pc;
            w_op2  = w_imm_u;
            w_we   = 1'b1;
        end else begin
            w_illegal = 1'b1;
        end
    end

    // Output bundle registers
    logic [OPC_W-1:0]   r_opcode;
    logic [XLEN-1:0]    r_op1;
    logic [XLEN-1:0]    r_op2;
    logic [XLEN-1:0]    r_pc;
    logic               r_rd_w_en;
    logic [RF_AW-1:0]   r_rd_w_addr;
    logic               r_illegal;

    // Pipeline register: reset > flush > accept > drain; stall holds everything
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_opcode    <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_pc        <= '0;
            r_rd_w_en   <= 1'b0;
            r_rd_w_addr <= '0;
            r_illegal   <= 1'b0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_opcode    <= w_code;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_pc        <= bus.in_pc;
            // Writes to x0 are architecturally discarded
            r_rd_w_en   <= w_we & (w_rd != '0);
            r_rd_w_addr <= w_rd;
            r_illegal   <= w_illegal;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid     = r_out_valid;
    assign bus.out_opcode    = r_opcode;
    assign bus.out_op1       = r_op1;
    assign bus.out_op2       = r_op2;
    assign bus.out_pc        = r_pc;
    assign bus.out_rd_w_en   = r_rd_w_en;
    assign bus.out_rd_w_addr = r_rd_w_addr;
    assign bus.out_illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040237_idu_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_22040237_idu_stage
//  Description : Self-checking bench for the decode stage: mnemonic-level
//                reference model plus directed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040237_idu_stage;

    localparam int XLEN  = 64;
    localparam int OPC_W = 8;
    localparam int RF_AW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22040237_idu_stage_if #(.XLEN(XLEN), .OPC_W(OPC_W), .RF_AW(RF_AW)) bus ();

    ysyx_22040237_idu_stage #(.XLEN(XLEN), .OPC_W(OPC_W), .RF_AW(RF_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file contents presented on the read ports
    logic [63:0] rf [32];
    assign bus.rs1_data = rf[bus.rs1_r_addr];
    assign bus.rs2_data = rf[bus.rs2_r_addr];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0]  code;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [63:0] pc;
        logic        we;
        logic [4:0]  rd;
        logic        ill;
    } bundle_t;

    function automatic string mnem(input logic [31:0] i);
        if (i == 32'h0010_0073) return "EBREAK";
        if (i[6:0] == 7'h13 && i[14:12] == 3'd0) return "ADDI";
        if (i[6:0] == 7'h33 && i[14:12] == 3'd0 && i[31:25] == 7'h00) return "ADD";
        if (i[6:0] == 7'h33 && i[14:12] == 3'd0 && i[31:25] == 7'h20) return "SUB";
        if (i[6:0] == 7'h37) return "LUI";
        if (i[6:0] == 7'h17) return "AUIPC";
        return "ILL";
    endfunction

    function automatic bundle_t decode(input logic [31:0] i, input logic [63:0] pc);
        bundle_t b;
        string   m;
        logic [63:0] uimm;
        m    = mnem(i);
        uimm = {{32{i[31]}}, i[31:12], 12'h000};
        b    = '0;
        b.pc = pc;
        b.rd = i[11:7];
        if (m == "ADDI") begin
            b.code = 8'h11; b.op1 = rf[i[19:15]]; b.op2 = {{52{i[31]}}, i[31:20]}; b.we = 1'b1;
        end else if (m == "ADD") begin
            b.code = 8'h01; b.op1 = rf[i[19:15]]; b.op2 = rf[i[24:20]]; b.we = 1'b1;
        end else if (m == "SUB") begin
            b.code = 8'h02; b.op1 = rf[i[19:15]]; b.op2 = rf[i[24:20]]; b.we = 1'b1;
        end else if (m == "LUI") begin
            b.code = 8'h21; b.op2 = uimm; b.we = 1'b1;
        end else if (m == "AUIPC") begin
            b.code = 8'h22; b.op1 = pc; b.op2 = uimm; b.we = 1'b1;
        end else if (m == "EBREAK") begin
            b.code = 8'hF0;
        end else begin
            b.ill = 1'b1;
        end
        if (b.rd == 5'd0) b.we = 1'b0;
        return b;
    endfunction

    logic    m_valid   = 1'b0;
    bundle_t m_b       = '0;
    logic    m_started = 1'b0;
    logic    m_in_ready;
    assign m_in_ready = !m_valid || bus.out_ready;

    // Model state advance
    always @(posedge clk) begin
        m_started <= 1'b1;
        if (rst) begin
            m_valid <= 1'b0;
            m_b     <= '0;
        end else if (bus.flush) begin
            m_valid <= 1'b0;
        end else if (bus.in_valid && m_in_ready) begin
            m_valid <= 1'b1;
            m_b     <= decode(bus.in_inst, bus.in_pc);
        end else if (bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_started) begin
            string m;
            logic  en1, en2, xfer;
            m    = mnem(bus.in_inst);
            xfer = !rst && bus.in_valid && m_in_ready;
            en1  = xfer && (m == "ADDI" || m == "ADD" || m == "SUB");
            en2  = xfer && (m == "ADD" || m == "SUB");
            chk("out_valid",  64'(bus.out_valid),  64'(m_valid));
            chk("in_ready",   64'(bus.in_ready),   64'(m_in_ready));
            chk("rs1_r_en",   64'(bus.rs1_r_en),   64'(en1));
            chk("rs2_r_en",   64'(bus.rs2_r_en),   64'(en2));
            chk("rs1_r_addr", 64'(bus.rs1_r_addr), en1 ? 64'(bus.in_inst[19:15]) : 64'd0);
            chk("rs2_r_addr", 64'(bus.rs2_r_addr), en2 ? 64'(bus.in_inst[24:20]) : 64'd0);
            if (m_valid) begin
                chk("out_opcode",    64'(bus.out_opcode),    64'(m_b.code));
                chk("out_op1",       bus.out_op1,            m_b.op1);
                chk("out_op2",       bus.out_op2,            m_b.op2);
                chk("out_pc",        bus.out_pc,             m_b.pc);
                chk("out_rd_w_en",   64'(bus.out_rd_w_en),   64'(m_b.we));
                chk("out_rd_w_addr", 64'(bus.out_rd_w_addr), 64'(m_b.rd));
                chk("out_illegal",   64'(bus.out_illegal),   64'(m_b.ill));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                         input logic ordy, input logic fl, input logic r);
        bus.in_valid  = v;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        bus.flush     = fl;
        rst           = r;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADDI  = 32'hFFD0_8293; // addi x5,x1,-3
    localparam logic [31:0] I_ADD   = 32'h0020_81B3; // add  x3,x1,x2
    localparam logic [31:0] I_SUB   = 32'h4020_8233; // sub  x4,x1,x2
    localparam logic [31:0] I_AUIPC = 32'h8000_0397; // auipc x7,0x80000
    localparam logic [31:0] I_LUI   = 32'h1234_5437; // lui  x8,0x12345
    localparam logic [31:0] I_ADDI0 = 32'h0010_0013; // addi x0,x0,1
    localparam logic [31:0] I_BAD   = 32'hFFFF_FFFF;
    localparam logic [31:0] I_EBRK  = 32'h0010_0073;

    initial begin
        for (int k = 0; k < 32; k++) rf[k] = 64'(k) * 64'd7;
        rf[1] = 64'd10;
        rf[2] = 64'd3;

        drive(0, 32'h0, 64'h0, 1, 0, 1);
        chk("rst_rs1_r_en", 64'(bus.rs1_r_en), 64'd0);
        tick();
        drive(1, I_ADD, 64'h0, 1, 0, 1);
        chk("rst_rs2_r_en", 64'(bus.rs2_r_en), 64'd0);
        chk("rst_rs1_addr", 64'(bus.rs1_r_addr), 64'd0);
        tick();

        // Reset state
        drive(0, 32'h0, 64'h0, 1, 0, 0);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_in_ready",  64'(bus.in_ready),  64'd1);
        chk("reset_opcode",    64'(bus.out_opcode), 64'd0);
        chk("reset_op1",       bus.out_op1, 64'd0);
        chk("reset_op2",       bus.out_op2, 64'd0);
        tick();

        // ADDI then ADD/SUB back-to-back, AUIPC
        drive(1, I_ADDI, 64'h100, 1, 0, 0);
        chk("addi_rs1_en",   64'(bus.rs1_r_en),   64'd1);
        chk("addi_rs1_addr", 64'(bus.rs1_r_addr), 64'd1);
        chk("addi_rs2_en",   64'(bus.rs2_r_en),   64'd0);
        tick();
        drive(1, I_ADD, 64'h104, 1, 0, 0);
        chk("addi_valid",  64'(bus.out_valid),  64'd1);
        chk("addi_opcode", 64'(bus.out_opcode), 64'h11);
        chk("addi_op1",    bus.out_op1, 64'd10);
        chk("addi_op2",    bus.out_op2, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("addi_we",     64'(bus.out_rd_w_en),   64'd1);
        chk("addi_rd",     64'(bus.out_rd_w_addr), 64'd5);
        chk("add_rs2_addr", 64'(bus.rs2_r_addr), 64'd2);
        tick();
        drive(1, I_SUB, 64'h108, 1, 0, 0);
        chk("add_opcode",   64'(bus.out_opcode), 64'h01);
        chk("add_op2",      bus.out_op2, 64'd3);
        chk("sub_rs2_addr", 64'(bus.rs2_r_addr), 64'd2);
        tick();
        drive(1, I_AUIPC, 64'h8000_0000, 1, 0, 0);
        chk("sub_opcode", 64'(bus.out_opcode), 64'h02);
        chk("sub_rd",     64'(bus.out_rd_w_addr), 64'd4);
        tick();

        // Stall three cycles with LUI waiting
        for (int s = 0; s < 3; s++) begin
            drive(1, I_LUI, 64'h200, 0, 0, 0);
            chk("stall_opcode",   64'(bus.out_opcode), 64'h22);
            chk("stall_op1",      bus.out_op1, 64'h8000_0000);
            chk("stall_op2",      bus.out_op2, 64'hFFFF_FFFF_8000_0000);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            tick();
        end
        drive(1, I_LUI, 64'h200, 1, 0, 0);
        chk("release_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        drive(1, I_ADDI0, 64'h204, 1, 0, 0);
        chk("lui_opcode", 64'(bus.out_opcode), 64'h21);
        chk("lui_op1",    bus.out_op1, 64'd0);
        chk("lui_op2",    bus.out_op2, 64'h0000_0000_1234_5000);
        chk("lui_pc",     bus.out_pc,  64'h200);
        tick();
        drive(1, I_BAD, 64'h208, 1, 0, 0);
        chk("x0_opcode", 64'(bus.out_opcode),  64'h11);
        chk("x0_we",     64'(bus.out_rd_w_en), 64'd0);
        tick();
        drive(1, I_EBRK, 64'h20C, 1, 0, 0);
        chk("ill_valid",   64'(bus.out_valid),   64'd1);
        chk("ill_flag",    64'(bus.out_illegal), 64'd1);
        chk("ill_opcode",  64'(bus.out_opcode),  64'h00);
        chk("ill_we",      64'(bus.out_rd_w_en), 64'd0);
        tick();
        drive(0, 32'h0, 64'h0, 1, 0, 0);
        chk("ebrk_opcode",  64'(bus.out_opcode),  64'hF0);
        chk("ebrk_illegal", 64'(bus.out_illegal), 64'd0);
        tick();
        drive(0, 32'h0, 64'h0, 1, 0, 0);
        chk("drain_valid", 64'(bus.out_valid), 64'd0);
        tick();

        // Flush over a stalled bundle with an incoming instruction
        drive(1, I_ADD, 64'h300, 1, 0, 0);
        tick();
        drive(1, I_SUB, 64'h304, 0, 0, 0);
        chk("pre_flush_opcode", 64'(bus.out_opcode), 64'h01);
        tick();
        drive(1, I_SUB, 64'h304, 0, 1, 0);
        tick();
        drive(0, 32'h0, 64'h0, 1, 0, 0);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        tick();
        drive(0, 32'h0, 64'h0, 1, 0, 0);
        chk("flush_valid2", 64'(bus.out_valid), 64'd0);
        tick();

        // Reset over a stalled bundle with an incoming instruction
        drive(1, I_ADD, 64'h400, 1, 0, 0);
        tick();
        drive(1, I_SUB, 64'h404, 0, 0, 0);
        tick();
        drive(1, I_SUB, 64'h404, 0, 0, 1);
        chk("midrst_rs1_en", 64'(bus.rs1_r_en), 64'd0);
        tick();
        drive(0, 32'h0, 64'h0, 1, 0, 0);
        chk("rst2_valid",   64'(bus.out_valid),     64'd0);
        chk("rst2_opcode",  64'(bus.out_opcode),    64'd0);
        chk("rst2_op1",     bus.out_op1,            64'd0);
        chk("rst2_op2",     bus.out_op2,            64'd0);
        chk("rst2_pc",      bus.out_pc,             64'd0);
        chk("rst2_rd",      64'(bus.out_rd_w_addr), 64'd0);
        chk("rst2_we",      64'(bus.out_rd_w_en),   64'd0);
        chk("rst2_ready",   64'(bus.in_ready),      64'd1);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
